mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over multiple cycles and holds the HI/LO architectural registers.
- Serves mthi/mtlo/mfhi/mflo.
- Exports start/busy so the hazard unit can stall any D-stage multiply/divide-class instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, others none.
- start  input  1  E-stage instruction is mult/multu/div/divu/madd/maddu; qualifies md_op 1-4, 9-10.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  operation in flight.
- hi  output  32  current HI.
- lo  output  32  current LO.
- md_out  output  32  hi when md_op=7, lo when md_op=8, else 0; combinational.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, state IDLE, shadow result registers cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter > 0.
- IDLE -> RUN on a clk edge with start=1 and a valid op (1-4, 9-10):
  - latch the 64-bit result into shadow {rhi,rlo}.
  - counter loads MULT_CYCLES for mult/madd-class ops, DIV_CYCLES for div-class ops.
  - HI/LO remain unchanged.
- RUN:
  - each edge decrements the counter.
  - on the edge where counter==1: hi<=rhi, lo<=rlo, busy<=0, state IDLE.
- Timing: start sampled at edge t ⇒ busy high for cycles t+1..t+N; new hi/lo visible from cycle t+N+1, the same cycle busy falls.
- Arithmetic:
  - mult: {hi,lo} = signed A × signed B (64-bit).
  - multu: unsigned A × B.
  - div: lo = signed A/B truncated toward zero; hi = remainder with the sign of A.
  - divu: unsigned quotient/remainder.
  - Overflow case div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (B=0) for div/divu: operation still runs DIV_CYCLES with busy; hi/lo retain their pre-op values at completion.
- mthi/mtlo (md_op 5/6) in IDLE, start=0: hi<=A or lo<=A on the next edge; no busy.
- Any md_op 5/6 or start while busy=1 is ignored. The hazard unit guarantees this cannot occur; the bench checks that state is untouched.
- mfhi/mflo while busy: md_out returns the old hi/lo. The hazard unit must stall; the block does not protect this case.
- start=1 with md_op 5-8 or invalid: treated as no start.
- reset asserted during RUN: abandon the operation, return to reset values on that edge; shadow result discarded.
- start and reset on the same edge: reset wins.

Optional Feature:
- MDU_MADD_EN defined:
  - md_op 9 madd: {hi,lo} += signed A×B.
  - md_op 10 maddu: {hi,lo} += unsigned A×B.
  - Both use MULT_CYCLES latency.
  - The accumulate uses the {hi,lo} value at the start edge; the 64-bit sum wraps modulo 2^64.
- MDU_MADD_EN undefined: md_op 9/10 are treated as none (no busy, no state change).

Test Plan:
- reset, then mult A=0xFFFFFFFE (-2), B=3 with start pulse at edge t -> busy=1 cycles t+1..t+5; at t+6 busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Follow with divu A=7, B=0 -> busy 10 cycles, hi/lo unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 next cycle, busy stays 0. Then md_op=7 -> md_out=0x12345678; md_op=8 -> md_out=0x9ABCDEF0.
- start div 100/3, assert reset at busy cycle 4 -> next cycle busy=0, hi=0, lo=0. A mtlo issued during busy in a separate run is ignored.
- with MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu A=1, B=1 -> after 5 cycles hi=1, lo=0. Without the macro: same stimulus -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers for the E stage.
// Optional madd/maddu accumulate is compiled in when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_n, lo_n, rhi, rlo, rhi_n, rlo_n;

  logic [63:0] prod_s, prod_u, result;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, sq, sr, uq, ur;
  logic        is_mul, is_div;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = B[31] ? (~B + 32'd1) : B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign sq    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign sr    = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign uq    = (B == 32'd0) ? 32'd0 : A / B;
  assign ur    = (B == 32'd0) ? 32'd0 : A % B;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    result = {hi, lo};
    case (md_op)
      4'd1: begin is_mul = 1'b1; result = prod_s; end
      4'd2: begin is_mul = 1'b1; result = prod_u; end
      4'd3: begin is_div = 1'b1; if (B != 32'd0) result = {sr, sq}; end
      4'd4: begin is_div = 1'b1; if (B != 32'd0) result = {ur, uq}; end
`ifdef MDU_MADD_EN
      4'd9:  begin is_mul = 1'b1; result = {hi, lo} + prod_s; end
      4'd10: begin is_mul = 1'b1; result = {hi, lo} + prod_u; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    rhi_n   = rhi;
    rlo_n   = rlo;
    case (state)
      IDLE: begin
        if (start && (is_mul || is_div)) begin
          state_n        = RUN;
          {rhi_n, rlo_n} = result;
          cnt_n          = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_op == 4'd5) begin
          hi_n = A;
        end else if (md_op == 4'd6) begin
          lo_n = A;
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_n    = rhi;
          lo_n    = rlo;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      rhi   <= '0;
      rlo   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      rhi   <= rhi_n;
      rlo   <= rlo_n;
    end
  end

  assign busy   = (state == RUN);
  assign md_out = (md_op == 4'd7) ? hi : (md_op == 4'd8) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: completions and snapshots are queued by the
// stimulus and checked by an independent monitor at the falling edge.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start), .A(A), .B(B),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] hi; logic [31:0] lo; int len; } done_t;
  typedef struct { string name; logic [31:0] hi; logic [31:0] lo; logic [31:0] mdout; logic busy; } snap_t;

  done_t done_q[$];
  snap_t snap_q[$];
  logic  snap = 1'b0;
  logic  prev_busy = 1'b0;
  int    bcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a busy falling edge retires one queued operation.
  always @(negedge clk) begin
    done_t d;
    snap_t s;
    if (busy === 1'b1) bcnt++;
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: hi %08h lo %08h", hi, lo);
      end else begin
        d = done_q.pop_front();
        chk({d.name, "_hi"}, hi, d.hi);
        chk({d.name, "_lo"}, lo, d.lo);
        chk({d.name, "_busy_len"}, 32'(bcnt), 32'(d.len));
      end
      bcnt = 0;
    end
    prev_busy = busy;
    if (snap) begin
      s = snap_q.pop_front();
      chk({s.name, "_hi"}, hi, s.hi);
      chk({s.name, "_lo"}, lo, s.lo);
      chk({s.name, "_md_out"}, md_out, s.mdout);
      chk({s.name, "_busy"}, {31'd0, busy}, {31'd0, s.busy});
    end
  end

  task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    md_op = op; start = st; A = a; B = b;
    @(posedge clk); #1;
    md_op = 4'd0; start = 1'b0;
  endtask

  task automatic expect_done(input string name, input logic [31:0] h, input logic [31:0] l, input int len);
    done_q.push_back('{name, h, l, len});
  endtask

  task automatic snap_chk(input string name, input logic [3:0] op, input logic [31:0] h,
                          input logic [31:0] l, input logic [31:0] m, input logic b);
    snap_q.push_back('{name, h, l, m, b});
    md_op = op;
    snap  = 1'b1;
    @(negedge clk); #1;
    snap = 1'b0;
    @(posedge clk); #1;
    md_op = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy %0b expected 0", name, busy);
    end
  endtask

  task automatic op_run(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l, input int len);
    expect_done(name, h, l, len);
    drive(op, 1'b1, a, b);
    wait_idle(name);
  endtask

  initial begin
    reset = 1'b1; md_op = 4'd0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    snap_chk("reset", 4'd0, 32'h0, 32'h0, 32'h0, 1'b0);

    // mult with a mid-flight look at HI/LO
    expect_done("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    drive(4'd1, 1'b1, 32'hFFFFFFFE, 32'd3);
    snap_chk("mult_inflight", 4'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_idle("mult");

    op_run("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    op_run("mult_min", 4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5);
    op_run("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    op_run("divu_zero", 4'd4, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    op_run("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    op_run("div_negb", 4'd3, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 10);
    op_run("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 10);

    drive(4'd5, 1'b0, 32'h12345678, 32'h0);
    snap_chk("mthi", 4'd0, 32'h12345678, 32'h7FFFFFFC, 32'h0, 1'b0);
    drive(4'd6, 1'b0, 32'h9ABCDEF0, 32'h0);
    snap_chk("mtlo", 4'd0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0);
    snap_chk("mfhi", 4'd7, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 1'b0);
    snap_chk("mflo", 4'd8, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0);
    drive(4'd7, 1'b1, 32'd5, 32'd5);
    snap_chk("start_bad_op", 4'd0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0);

    // reset in busy cycle 4 abandons the divide
    expect_done("abort", 32'h0, 32'h0, 4);
    drive(4'd3, 1'b1, 32'd100, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    snap_chk("after_abort", 4'd0, 32'h0, 32'h0, 32'h0, 1'b0);

    // writes and a second start while busy must not disturb the operation
    expect_done("mult_guard", 32'h0, 32'h0000000C, 5);
    drive(4'd1, 1'b1, 32'd3, 32'd4);
    drive(4'd6, 1'b0, 32'hDEADBEEF, 32'h0);
    drive(4'd5, 1'b0, 32'hCAFEF00D, 32'h0);
    drive(4'd1, 1'b1, 32'd7, 32'd7);
    snap_chk("guard_inflight", 4'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    wait_idle("mult_guard");

    drive(4'd5, 1'b0, 32'h0, 32'h0);
    drive(4'd6, 1'b0, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
    op_run("maddu", 4'd10, 32'd1, 32'd1, 32'h1, 32'h0, 5);
    op_run("madd", 4'd9, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 5);
`else
    drive(4'd10, 1'b1, 32'd1, 32'd1);
    snap_chk("maddu_off", 4'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
    drive(4'd9, 1'b1, 32'hFFFFFFFF, 32'd1);
    snap_chk("madd_off", 4'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("pending_ops", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
